// File: rtl/sum_pkg.sv
// sum_pkg: shared constants, types and helpers for the sum_collect slice.
//   N_DEF / CC_DEF : default result width and slices per result
//   W_DEF          : derived slice width (N_DEF / CC_DEF)
//   cnt_w()        : width of a counter that must hold 0..cc inclusive
//   state_t        : collector state, FILL (assembling) or FULL (word ready)
package sum_pkg;

  localparam int N_DEF  = 1024;
  localparam int CC_DEF = 512;
  localparam int W_DEF  = N_DEF / CC_DEF;

  // Counter must reach cc itself (not just cc-1), hence cc+1 codes.
  function automatic int cnt_w(input int cc);
    return (cc < 1) ? 1 : $clog2(cc + 1);
  endfunction

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/sum_beat_counter.sv
// sum_beat_counter: 0..CC beat counter with synchronous clear and increment.
// Also used by the upstream operand serializer.
//   clk, rst  : clock, asynchronous active-high reset
//   i_clr     : synchronous clear to 0 (wins over i_inc)
//   i_inc     : count one beat; saturates at CC
//   o_count   : current count
//   o_last    : count equals CC-1, i.e. the next beat completes the word
module sum_beat_counter
  import sum_pkg::*;
#(
  parameter int CC = 4,
  parameter int CW = cnt_w(CC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_count,
  output logic          o_last
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != CW'(CC))) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == CW'(CC - 1));

endmodule

// File: rtl/sum_collect.sv
// sum_collect: assembles CC W-bit sum slices (LSB slice first) from the
// bit-serial adder into one N-bit word and offers it downstream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in FILL; result_valid is high only in FULL.
// Neither ready depends combinationally on its own valid.
//
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : c_in carries a slice
//   c_in         : W-bit sum slice
//   in_ready     : slice accepted this cycle (FILL)
//   flush        : synchronous abort, discards the word in any state
//   result       : assembled word, slice k at bits [k*W +: W]
//   result_valid : result is complete and held stable (FULL)
//   result_ready : consumer takes result this cycle
//   beat_cnt     : slices accepted into the current word (CC while FULL)
//   dbg_state    : current FSM state (state_t encoding)
module sum_collect
  import sum_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CC = CC_DEF,
  parameter int W  = N / CC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [W-1:0]           c_in,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [N-1:0]           result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [cnt_w(CC)-1:0]   beat_cnt,
  output logic                   dbg_state
);

  localparam int CW = cnt_w(CC);

  generate
    if ((N % CC) != 0) begin : g_bad_ratio
      $error("sum_collect: N must be a multiple of CC");
    end
  endgenerate

  state_t        r_state;
  logic [N-1:0]  r_result;
  logic [CW-1:0] w_cnt;
  logic          w_last;
  logic          w_accept;
  logic          w_take;
  logic          w_clr;

  // flush overrides both a same-cycle beat and a same-cycle handoff.
  assign w_accept = in_valid && (r_state == FILL) && !flush;
  assign w_take   = result_ready && (r_state == FULL) && !flush;
  assign w_clr    = flush || w_take;

  sum_beat_counter #(.CC(CC), .CW(CW)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_inc   (w_accept),
    .o_count (w_cnt),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else if (flush) begin
      r_state <= FILL;
    end else if (w_accept && w_last) begin
      r_state <= FULL;
    end else if (w_take) begin
      r_state <= FILL;
    end
  end

  // Slice position is decoded from the beat count; clearing on handoff keeps
  // unwritten positions at 0 while the next word fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_clr) begin
      r_result <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < CC; k++) begin
        if (w_cnt == CW'(k)) begin
          r_result[k*W +: W] <= c_in;
        end
      end
    end
  end

  assign in_ready     = (r_state == FILL);
  assign result_valid = (r_state == FULL);
  assign result       = r_result;
  assign beat_cnt     = w_cnt;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_sum_collect.sv
module tb_sum_collect;

  localparam int N  = 8;
  localparam int CC = 4;
  localparam int W  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] c_in;
  logic         in_ready;
  logic         flush;
  logic [N-1:0] result;
  logic         result_valid;
  logic         result_ready;
  logic [2:0]   beat_cnt;
  logic         dbg_state;

  int checks = 0;
  int errors = 0;

  sum_collect #(.N(N), .CC(CC), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .c_in         (c_in),
    .in_ready     (in_ready),
    .flush        (flush),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .beat_cnt     (beat_cnt),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // advance one edge, then sample away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    c_in     = d;
    step();
  endtask

  task automatic take_word();
    in_valid     = 1'b0;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; c_in = '0; flush = 1'b0; result_ready = 1'b0;
    #2;
    if (in_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: in_ready=%b result_valid=%b need 1/0", in_ready, result_valid);
    end
    checks++;
    if (result !== 8'h00 || beat_cnt !== 3'd0 || dbg_state !== 1'b0) begin
      errors++; $display("FAIL reset_regs: result=%h beat_cnt=%0d state=%b need 00/0/0", result, beat_cnt, dbg_state);
    end
    checks++;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill();
    send(2'b01);
    send(2'b10);
    send(2'b11);
    if (result !== 8'h39 & 8'h3F || result_valid !== 1'b0 || beat_cnt !== 3'd3) begin
      errors++; $display("FAIL fill_partial: result=%h valid=%b cnt=%0d need 39/0/3", result, result_valid, beat_cnt);
    end
    checks++;
    send(2'b00);
    in_valid = 1'b0;
    if (result !== 8'h39 || result_valid !== 1'b1) begin
      errors++; $display("FAIL fill_word: result=%h valid=%b need 39/1", result, result_valid);
    end
    checks++;
    if (in_ready !== 1'b0 || beat_cnt !== 3'd4) begin
      errors++; $display("FAIL fill_full: in_ready=%b cnt=%0d need 0/4", in_ready, beat_cnt);
    end
    checks++;
  endtask

  task automatic test_handoff();
    // FULL ignores in_valid and holds the word
    send(2'b10);
    if (result !== 8'h39 || beat_cnt !== 3'd4 || result_valid !== 1'b1) begin
      errors++; $display("FAIL hold_full: result=%h cnt=%0d valid=%b need 39/4/1", result, beat_cnt, result_valid);
    end
    checks++;
    // handshake cycle with a slice present: slice not taken
    result_ready = 1'b1;
    send(2'b11);
    result_ready = 1'b0;
    if (result !== 8'h00 || beat_cnt !== 3'd0 || result_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL handoff: result=%h cnt=%0d valid=%b rdy=%b need 00/0/0/1", result, beat_cnt, result_valid, in_ready);
    end
    checks++;
    send(2'b11);
    in_valid = 1'b0;
    if (result !== 8'h03 || beat_cnt !== 3'd1) begin
      errors++; $display("FAIL after_handoff: result=%h cnt=%0d need 03/1", result, beat_cnt);
    end
    checks++;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_gaps();
    logic       v_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] d_seq [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    logic [2:0] exp_cnt = 3'd0;
    int di = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = v_seq[i];
      c_in     = v_seq[i] ? d_seq[di] : 2'b10;
      if (v_seq[i]) begin di++; exp_cnt++; end
      step();
      if (beat_cnt !== exp_cnt) begin
        errors++; $display("FAIL gap_cnt[%0d]: cnt=%0d need %0d", i, beat_cnt, exp_cnt);
      end
      checks++;
    end
    in_valid = 1'b0;
    if (result !== 8'h1B || result_valid !== 1'b1) begin
      errors++; $display("FAIL gap_word: result=%h valid=%b need 1B/1", result, result_valid);
    end
    checks++;
    take_word();
  endtask

  task automatic test_flush();
    send(2'd3);
    send(2'd3);
    flush = 1'b1;
    send(2'd2);
    flush = 1'b0;
    in_valid = 1'b0;
    if (beat_cnt !== 3'd0 || result !== 8'h00 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush: cnt=%0d result=%h rdy=%b need 0/00/1", beat_cnt, result, in_ready);
    end
    checks++;
    for (int i = 0; i < 4; i++) send(2'd1);
    in_valid = 1'b0;
    if (result !== 8'h55 || result_valid !== 1'b1) begin
      errors++; $display("FAIL flush_next: result=%h valid=%b need 55/1", result, result_valid);
    end
    checks++;
    // flush beats a same-cycle result_ready and clears FULL
    flush = 1'b1; result_ready = 1'b1;
    step();
    flush = 1'b0; result_ready = 1'b0;
    if (result !== 8'h00 || result_valid !== 1'b0 || beat_cnt !== 3'd0) begin
      errors++; $display("FAIL flush_full: result=%h valid=%b cnt=%0d need 00/0/0", result, result_valid, beat_cnt);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    send(2'd2);
    send(2'd3);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    if (result !== 8'h00 || beat_cnt !== 3'd0 || in_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++; $display("FAIL async_rst: result=%h cnt=%0d rdy=%b valid=%b need 00/0/1/0", result, beat_cnt, in_ready, result_valid);
    end
    checks++;
    step();
    rst = 1'b0;
    send(2'd2);
    send(2'd1);
    send(2'd0);
    send(2'd3);
    in_valid = 1'b0;
    if (result !== 8'hC6 || result_valid !== 1'b1) begin
      errors++; $display("FAIL rst_frame: result=%h valid=%b need C6/1", result, result_valid);
    end
    checks++;
    take_word();
  endtask

  task automatic test_back_to_back();
    logic [1:0] fr  [3][4] = '{'{2'd0, 2'd1, 2'd2, 2'd3},
                               '{2'd3, 2'd3, 2'd0, 2'd1},
                               '{2'd2, 2'd2, 2'd2, 2'd2}};
    logic [7:0] exp [3] = '{8'hE4, 8'h4F, 8'hAA};
    result_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 4; s++) begin
        if (result_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_early[%0d.%0d]: valid=%b need 0", f, s, result_valid);
        end
        checks++;
        send(fr[f][s]);
      end
      if (result !== exp[f] || result_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_word[%0d]: result=%h valid=%b need %h/1", f, result, result_valid, exp[f]);
      end
      checks++;
      send(2'b11); // handshake cycle, slice ignored
    end
    result_ready = 1'b0;
    in_valid = 1'b0;
    if (result !== 8'h00 || beat_cnt !== 3'd0) begin
      errors++; $display("FAIL b2b_end: result=%h cnt=%0d need 00/0", result, beat_cnt);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_handoff();
    test_gaps();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
